// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package pc_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    // Canonical NOP (addi x0, x0, 0) loaded into IF/ID on reset
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Sequential PC step
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_e;

    // One fetched instruction together with its address
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_payload_t;

    // True when an address is on a 4-byte boundary
    function automatic logic word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if_id_register.sv
// IF/ID pipeline register: enable, synchronous flush, reset to a NOP bubble.
module if_id_register
    import pc_fetch_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                flush,
    input  logic                load,
    input  if_id_payload_t      d,
    output logic [XLEN-1:0]     pc_o,
    output logic [XLEN-1:0]     pc4_o,
    output logic [XLEN-1:0]     instr_o,
    output logic                valid_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;

    // Flush wins over enable; an enabled cycle without a load becomes a bubble
    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (en) begin
            if (load) begin
                pc_d    = d.pc;
                pc4_d   = d.pc + PC_INC;
                instr_d = d.instr;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // Register update with synchronous reset to the NOP bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            pc4_q   <= PC_INC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC, busywait fetch handshake, stall hold buffer,
// redirect with in-flight drop. Optional macro PC_ALIGN_CHECK_EN adds a
// sticky misaligned-target flag and parks fetch on a misaligned target.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic                branch_jump_mux_signal,
    input  logic [XLEN-1:0]     Branch_jump_PC_OUT,
    input  logic                stall,
    output logic                imem_read,
    output logic [XLEN-1:0]     imem_address,
    input  logic [XLEN-1:0]     imem_readdata,
    input  logic                imem_busywait,
    output logic [XLEN-1:0]     if_id_pc,
    output logic [XLEN-1:0]     if_id_pc4,
    output logic [XLEN-1:0]     if_id_instr,
    output logic                if_id_valid
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                pc_misaligned
`endif
);

    fetch_state_e   state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    if_id_payload_t hold_q, hold_d;
    logic           imem_read_q, imem_read_d;
`ifdef PC_ALIGN_CHECK_EN
    logic           park_q, park_d;
    logic           misal_q, misal_d;
`endif

    logic           done_c;
    logic           outstanding_c;
    logic           ifid_load_c;
    if_id_payload_t ifid_data_c;

    // Memory handshake status for the access presented this cycle
    assign done_c        = imem_read_q & ~imem_busywait;
    assign outstanding_c = imem_read_q &  imem_busywait;

    // Next-state, PC, hold buffer and IF/ID load selection
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        hold_d      = hold_q;
        ifid_load_c = 1'b0;
        ifid_data_c = hold_q;
`ifdef PC_ALIGN_CHECK_EN
        park_d      = park_q;
        misal_d     = misal_q;
`endif

        if (branch_jump_mux_signal) begin
            hold_d = '0;
            if (outstanding_c) begin
                // Access in flight: let it finish, then jump
                pend_d  = Branch_jump_PC_OUT;
                state_d = S_DROP;
            end else begin
                pc_d    = Branch_jump_PC_OUT;
                state_d = S_FETCH;
`ifdef PC_ALIGN_CHECK_EN
                park_d  = ~word_aligned(Branch_jump_PC_OUT);
                misal_d = misal_q | ~word_aligned(Branch_jump_PC_OUT);
`endif
            end
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (done_c) begin
                        pc_d = pc_q + PC_INC;
                        if (stall) begin
                            hold_d.pc    = pc_q;
                            hold_d.instr = imem_readdata;
                            state_d      = S_HOLD;
                        end else begin
                            ifid_load_c       = 1'b1;
                            ifid_data_c.pc    = pc_q;
                            ifid_data_c.instr = imem_readdata;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifid_load_c = 1'b1;
                        ifid_data_c = hold_q;
                        hold_d      = '0;
                        state_d     = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (done_c) begin
                        pc_d    = pend_q;
                        state_d = S_FETCH;
`ifdef PC_ALIGN_CHECK_EN
                        park_d  = ~word_aligned(pend_q);
                        misal_d = misal_q | ~word_aligned(pend_q);
`endif
                    end
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end

`ifdef PC_ALIGN_CHECK_EN
        imem_read_d = (state_d != S_HOLD) && !park_d;
`else
        imem_read_d = (state_d != S_HOLD);
`endif
    end

    // State, PC and fetch-request registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            pend_q      <= '0;
            hold_q      <= '0;
            imem_read_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            park_q      <= 1'b0;
            misal_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            hold_q      <= hold_d;
            imem_read_q <= imem_read_d;
`ifdef PC_ALIGN_CHECK_EN
            park_q      <= park_d;
            misal_q     <= misal_d;
`endif
        end
    end

    assign imem_read    = imem_read_q;
    assign imem_address = pc_q;
`ifdef PC_ALIGN_CHECK_EN
    assign pc_misaligned = misal_q;
`endif

    if_id_register u_if_id (
        .clk     (CLK),
        .rst     (RESET),
        .en      (~stall),
        .flush   (branch_jump_mux_signal),
        .load    (ifid_load_c),
        .d       (ifid_data_c),
        .pc_o    (if_id_pc),
        .pc4_o   (if_id_pc4),
        .instr_o (if_id_instr),
        .valid_o (if_id_valid)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: scripted scenarios plus an
// in-order scoreboard of the instructions expected to enter IF/ID.
module tb_pc_fetch_unit;

    localparam logic [31:0] TB_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redir;
    logic [31:0] tgt;
    logic        stall;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_readdata;
    logic        busy;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
`ifdef PC_ALIGN_CHECK_EN
    logic        pc_misaligned;
`endif

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000 ^ {a[7:0], 24'h0};
    endfunction

    assign imem_readdata = mem_word(imem_address);

    pc_fetch_unit dut (
        .CLK                    (clk),
        .RESET                  (rst),
        .branch_jump_mux_signal (redir),
        .Branch_jump_PC_OUT     (tgt),
        .stall                  (stall),
        .imem_read              (imem_read),
        .imem_address           (imem_address),
        .imem_readdata          (imem_readdata),
        .imem_busywait          (busy),
        .if_id_pc               (if_id_pc),
        .if_id_pc4              (if_id_pc4),
        .if_id_instr            (if_id_instr),
        .if_id_valid            (if_id_valid)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .pc_misaligned          (pc_misaligned)
`endif
    );

    // Scoreboard: every fresh IF/ID load must match the oldest expected PC
    always @(posedge clk) begin : monitor
        logic        st, rd, rs;
        logic [31:0] e;
        st = stall;
        rd = redir;
        rs = rst;
        #1;
        if (if_id_valid === 1'b1 && !st && !rd && !rs) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL ifid_unexpected: got pc=%h, wanted no instruction", if_id_pc);
            end else begin
                e = exp_q.pop_front();
                if (if_id_pc !== e || if_id_pc4 !== e + 32'd4 || if_id_instr !== mem_word(e))
                    $display("FAIL ifid_entry: got pc=%h pc4=%h instr=%h, wanted pc=%h pc4=%h instr=%h",
                             if_id_pc, if_id_pc4, if_id_instr, e, e + 32'd4, mem_word(e));
                else
                    n_pass++;
            end
        end
    end

    // Advance one cycle; inputs change and outputs are sampled 2 units after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; redir = 1'b0; tgt = '0; stall = 1'b0; busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++;
            if (imem_read !== 1'b0 || if_id_valid !== 1'b0)
                $display("FAIL reset_ctrl: got read=%b valid=%b, wanted 0 0", imem_read, if_id_valid);
            else n_pass++;
        end
        n_total++;
        if (if_id_instr !== TB_NOP || if_id_pc !== 32'h0 || if_id_pc4 !== 32'h4 || imem_address !== 32'h0)
            $display("FAIL reset_regs: got instr=%h pc=%h pc4=%h addr=%h, wanted %h 0 4 0",
                     if_id_instr, if_id_pc, if_id_pc4, imem_address, TB_NOP);
        else n_pass++;
`ifdef PC_ALIGN_CHECK_EN
        n_total++;
        if (pc_misaligned !== 1'b0) $display("FAIL reset_misal: got %b, wanted 0", pc_misaligned);
        else n_pass++;
`endif
    endtask

    task automatic test_zero_wait();
        logic [31:0] want_addr[3];
        logic        want_vld[3];
        want_addr[0] = 32'h0; want_addr[1] = 32'h4; want_addr[2] = 32'h8;
        want_vld[0]  = 1'b0;  want_vld[1]  = 1'b1;  want_vld[2]  = 1'b1;
        rst = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (imem_address !== want_addr[i] || imem_read !== 1'b1 || if_id_valid !== want_vld[i])
                $display("FAIL zw_cycle%0d: got addr=%h read=%b valid=%b, wanted %h 1 %b",
                         i, imem_address, imem_read, if_id_valid, want_addr[i], want_vld[i]);
            else n_pass++;
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL zw_drain: got %0d pending, wanted 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_wait_states();
        busy = 1'b1;
        exp_q.push_back(32'h8);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (imem_address !== 32'h8 || if_id_valid !== 1'b0)
                $display("FAIL ws_busy%0d: got addr=%h valid=%b, wanted 8 0", i, imem_address, if_id_valid);
            else n_pass++;
        end
        busy = 1'b0;
        tick();
        n_total++;
        if (imem_address !== 32'hC || if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'h8))
            $display("FAIL ws_done: got addr=%h valid=%b instr=%h, wanted c 1 %h",
                     imem_address, if_id_valid, if_id_instr, mem_word(32'h8));
        else n_pass++;
    endtask

    task automatic test_redirect_busy();
        busy = 1'b1;
        tick();
        redir = 1'b1; tgt = 32'h100;
        tick();
        n_total++;
        if (imem_address !== 32'hC || imem_read !== 1'b1 || if_id_valid !== 1'b0)
            $display("FAIL rb_drop: got addr=%h read=%b valid=%b, wanted c 1 0", imem_address, imem_read, if_id_valid);
        else n_pass++;
        redir = 1'b0;
        tick();
        n_total++;
        if (imem_address !== 32'hC) $display("FAIL rb_frozen: got addr=%h, wanted c", imem_address);
        else n_pass++;
        busy = 1'b0;
        tick();
        n_total++;
        if (imem_address !== 32'h100 || if_id_valid !== 1'b0)
            $display("FAIL rb_target: got addr=%h valid=%b, wanted 100 0", imem_address, if_id_valid);
        else n_pass++;
        exp_q.push_back(32'h100);
        tick();
        n_total++;
        if (imem_address !== 32'h104 || exp_q.size() != 0)
            $display("FAIL rb_resume: got addr=%h pending=%0d, wanted 104 0", imem_address, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_stall();
        redir = 1'b1; tgt = 32'h1C;
        tick();
        redir = 1'b0;
        exp_q.push_back(32'h1C);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++;
            if (imem_read !== 1'b0 || if_id_pc !== 32'h1C || if_id_valid !== 1'b1 || imem_address !== 32'h24)
                $display("FAIL st_hold%0d: got read=%b pc=%h valid=%b addr=%h, wanted 0 1c 1 24",
                         i, imem_read, if_id_pc, if_id_valid, imem_address);
            else n_pass++;
        end
        stall = 1'b0;
        exp_q.push_back(32'h20);
        tick();
        n_total++;
        if (if_id_pc !== 32'h20 || if_id_pc4 !== 32'h24 || if_id_instr !== mem_word(32'h20) || imem_read !== 1'b1)
            $display("FAIL st_release: got pc=%h pc4=%h instr=%h read=%b, wanted 20 24 %h 1",
                     if_id_pc, if_id_pc4, if_id_instr, imem_read, mem_word(32'h20));
        else n_pass++;
        exp_q.push_back(32'h24);
        tick();
        n_total++;
        if (imem_address !== 32'h28 || exp_q.size() != 0)
            $display("FAIL st_resume: got addr=%h pending=%0d, wanted 28 0", imem_address, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1;
        tick();
        redir = 1'b1; tgt = 32'h40;
        tick();
        n_total++;
        if (if_id_valid !== 1'b0 || imem_address !== 32'h40 || imem_read !== 1'b1)
            $display("FAIL rs_flush: got valid=%b addr=%h read=%b, wanted 0 40 1", if_id_valid, imem_address, imem_read);
        else n_pass++;
        redir = 1'b0; stall = 1'b0;
        exp_q.push_back(32'h40);
        tick();
        n_total++;
        if (if_id_pc !== 32'h40 || exp_q.size() != 0)
            $display("FAIL rs_next: got pc=%h pending=%0d, wanted 40 0", if_id_pc, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_wrap();
        redir = 1'b1; tgt = 32'hFFFF_FFFC;
        tick();
        redir = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC);
        tick();
        n_total++;
        if (if_id_pc4 !== 32'h0 || imem_address !== 32'h0)
            $display("FAIL wrap: got pc4=%h addr=%h, wanted 0 0", if_id_pc4, imem_address);
        else n_pass++;
    endtask

    task automatic test_reset_in_drop();
        busy = 1'b1; redir = 1'b1; tgt = 32'h300;
        tick();
        redir = 1'b0; rst = 1'b1;
        tick();
        n_total++;
        if (imem_read !== 1'b0 || imem_address !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== TB_NOP)
            $display("FAIL rd_reset: got read=%b addr=%h valid=%b instr=%h, wanted 0 0 0 %h",
                     imem_read, imem_address, if_id_valid, if_id_instr, TB_NOP);
        else n_pass++;
        rst = 1'b0; busy = 1'b0;
        tick();
        exp_q.push_back(32'h0);
        tick();
        n_total++;
        if (imem_address !== 32'h4 || exp_q.size() != 0)
            $display("FAIL rd_restart: got addr=%h pending=%0d, wanted 4 0", imem_address, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_misaligned();
        redir = 1'b1; tgt = 32'h102;
        tick();
        redir = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (pc_misaligned !== 1'b1 || imem_read !== 1'b0 || imem_address !== 32'h102 || if_id_valid !== 1'b0)
                $display("FAIL ma_park%0d: got misal=%b read=%b addr=%h valid=%b, wanted 1 0 102 0",
                         i, pc_misaligned, imem_read, imem_address, if_id_valid);
            else n_pass++;
            tick();
        end
        redir = 1'b1; tgt = 32'h200;
        tick();
        redir = 1'b0;
        n_total++;
        if (pc_misaligned !== 1'b1 || imem_read !== 1'b1 || imem_address !== 32'h200)
            $display("FAIL ma_resume: got misal=%b read=%b addr=%h, wanted 1 1 200",
                     pc_misaligned, imem_read, imem_address);
        else n_pass++;
        exp_q.push_back(32'h200);
        tick();
`else
        n_total++;
        if (imem_read !== 1'b1 || imem_address !== 32'h102)
            $display("FAIL ma_verbatim: got read=%b addr=%h, wanted 1 102", imem_read, imem_address);
        else n_pass++;
        exp_q.push_back(32'h102);
        tick();
`endif
        n_total++;
        if (exp_q.size() != 0) $display("FAIL ma_drain: got %0d pending, wanted 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_redirect_busy();
        test_stall();
        test_redirect_stall();
        test_wrap();
        test_reset_in_drop();
        test_misaligned();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
